vend_change_dispenser: RTL and testbench

//  Pays out change owed by the vending FSM: loads a cent amount, ejects coins one at a time
//  (greedy: quarter > dime > nickel) through a req/ack handshake to the coin hopper, and tracks
//  per-denomination inventory. Sits between the vending controller (credit side) and the hopper.

---
 rtl/vend_change_if.sv | 36 +++
 rtl/vend_change_dispenser.sv | 159 +++++++++++++++
 tb/tb_vend_change_dispenser.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vend_change_if.sv
// Bundle between the vending controller and the change dispenser.
// master = controller / test driver, slave = dispenser.
`timescale 1ns/1ps
interface vend_change_if #(
  parameter int AMT_W = 6,
  parameter int INV_W = 4
);
  logic             start;
  logic [AMT_W-1:0] change_amt;
  logic             coin_ack;
  logic             refill;
  logic             clear_fault;
  logic             eject_q;
  logic             eject_d;
  logic             eject_n;
  logic             busy;
  logic             done;
  logic             fault;
  logic [1:0]       err_code;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] q_cnt;
  logic [INV_W-1:0] d_cnt;
  logic [INV_W-1:0] n_cnt;

  modport master (
    output start, change_amt, coin_ack, refill, clear_fault,
    input  eject_q, eject_d, eject_n, busy, done, fault, err_code,
           remaining, q_cnt, d_cnt, n_cnt
  );

  modport slave (
    input  start, change_amt, coin_ack, refill, clear_fault,
    output eject_q, eject_d, eject_n, busy, done, fault, err_code,
           remaining, q_cnt, d_cnt, n_cnt
  );
endinterface

// File: rtl/vend_change_dispenser.sv
// Change dispenser: greedy quarter/dime/nickel payout over a req/ack hopper
// handshake, with per-denomination inventory.
// Optional: CHANGE_AUDIT_EN adds audit_total, a saturating count of cents ejected.
`timescale 1ns/1ps
module vend_change_dispenser #(
  parameter int AMT_W       = 6,
  parameter int INV_W       = 4,
  parameter int Q_INIT      = 8,
  parameter int D_INIT      = 8,
  parameter int N_INIT      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  vend_change_if.slave bus
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [15:0]  audit_total
`endif
);
  localparam int WC_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE, S_FAULT} state_t;
  typedef enum logic [1:0] {C_NONE, C_Q, C_D, C_N} coin_t;

  state_t           state, state_nxt;
  coin_t            sel, sel_nxt;
  logic             err_set;
  logic [1:0]       err_nxt;
  logic [WC_W-1:0]  wcnt;
  logic [AMT_W-1:0] rem;
  logic [INV_W-1:0] q_cnt, d_cnt, n_cnt;
  logic [AMT_W-1:0] coin_val;
  logic             acked;

  assign acked = (state == S_EJECT) && bus.coin_ack;

  // value of the coin currently being ejected
  always_comb begin
    coin_val = '0;
    case (sel)
      C_Q:     coin_val = AMT_W'(25);
      C_D:     coin_val = AMT_W'(10);
      C_N:     coin_val = AMT_W'(5);
      default: coin_val = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;

  // next-state, coin selection and error capture
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    err_set   = 1'b0;
    err_nxt   = 2'd0;
    case (state)
      S_IDLE:
        if (bus.start) begin
          if (bus.change_amt % AMT_W'(5) != '0) begin
            state_nxt = S_FAULT; err_set = 1'b1; err_nxt = 2'd1;
          end else if (bus.change_amt == '0) state_nxt = S_DONE;
          else                               state_nxt = S_SELECT;
        end
      S_SELECT:
        if (rem == '0)                                  state_nxt = S_DONE;
        else if (rem >= AMT_W'(25) && q_cnt != '0) begin state_nxt = S_EJECT; sel_nxt = C_Q; end
        else if (rem >= AMT_W'(10) && d_cnt != '0) begin state_nxt = S_EJECT; sel_nxt = C_D; end
        else if (rem >= AMT_W'(5)  && n_cnt != '0) begin state_nxt = S_EJECT; sel_nxt = C_N; end
        else begin
          state_nxt = S_FAULT; err_set = 1'b1; err_nxt = 2'd2;
        end
      S_EJECT:
        if (bus.coin_ack) state_nxt = S_GAP;
        else if (wcnt == WC_W'(ACK_TIMEOUT - 1)) begin
          state_nxt = S_FAULT; err_set = 1'b1; err_nxt = 2'd3;
        end
      S_GAP:   state_nxt = S_SELECT;
      S_DONE:  state_nxt = S_IDLE;
      S_FAULT: if (bus.clear_fault) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // datapath: remaining amount, inventories, ack wait counter, error code
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sel          <= C_NONE;
      wcnt         <= '0;
      rem          <= '0;
      bus.err_code <= 2'd0;
      q_cnt        <= INV_W'(Q_INIT);
      d_cnt        <= INV_W'(D_INIT);
      n_cnt        <= INV_W'(N_INIT);
    end else begin
      sel  <= sel_nxt;
      wcnt <= (state == S_EJECT) ? wcnt + 1'b1 : '0;
      if (err_set) bus.err_code <= err_nxt;
      if (state == S_IDLE && bus.start && state_nxt == S_SELECT) rem <= bus.change_amt;
      if (state == S_FAULT && bus.clear_fault) begin
        rem          <= '0;
        bus.err_code <= 2'd0;
      end
      if (bus.refill && (state == S_IDLE || state == S_FAULT)) begin
        q_cnt <= INV_W'(Q_INIT);
        d_cnt <= INV_W'(D_INIT);
        n_cnt <= INV_W'(N_INIT);
      end
      // greedy guards in SELECT keep rem and the counts from underflowing
      if (acked) begin
        rem <= rem - coin_val;
        case (sel)
          C_Q:     q_cnt <= q_cnt - 1'b1;
          C_D:     d_cnt <= d_cnt - 1'b1;
          C_N:     n_cnt <= n_cnt - 1'b1;
          default: ;
        endcase
      end
    end

  // registered status outputs, derived from the upcoming state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.eject_q <= 1'b0;
      bus.eject_d <= 1'b0;
      bus.eject_n <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.fault   <= 1'b0;
    end else begin
      bus.eject_q <= (state_nxt == S_EJECT) && (sel_nxt == C_Q);
      bus.eject_d <= (state_nxt == S_EJECT) && (sel_nxt == C_D);
      bus.eject_n <= (state_nxt == S_EJECT) && (sel_nxt == C_N);
      bus.busy    <= (state_nxt == S_SELECT) || (state_nxt == S_EJECT) ||
                     (state_nxt == S_GAP)    || (state_nxt == S_DONE);
      bus.done    <= (state_nxt == S_DONE);
      bus.fault   <= (state_nxt == S_FAULT);
    end

  assign bus.remaining = rem;
  assign bus.q_cnt     = q_cnt;
  assign bus.d_cnt     = d_cnt;
  assign bus.n_cnt     = n_cnt;

`ifdef CHANGE_AUDIT_EN
  logic [16:0] audit_sum;

  // saturating sum of ejected cents
  always_comb audit_sum = {1'b0, audit_total} + 17'(coin_val);

  // cumulative audit counter, only reset clears it
  always_ff @(posedge clk or posedge reset)
    if (reset)      audit_total <= '0;
    else if (acked) audit_total <= audit_sum[16] ? 16'hFFFF : audit_sum[15:0];
`endif
endmodule

// File: tb/tb_vend_change_dispenser.sv
// Scoreboard bench for vend_change_dispenser: expected hopper events queued by
// the stimulus, popped and compared by an independent monitor.
`timescale 1ns/1ps
module tb_vend_change_dispenser;
  localparam int AMT_W = 6, INV_W = 4, TO = 15;
  // event codes: 1 quarter, 2 dime, 3 nickel, 4 done, 4+err fault
  localparam int EV_Q = 1, EV_D = 2, EV_N = 3, EV_DONE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vend_change_if #(.AMT_W(AMT_W), .INV_W(INV_W)) bus ();
`ifdef CHANGE_AUDIT_EN
  logic [15:0] audit_total;
`endif

  vend_change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .ACK_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CHANGE_AUDIT_EN
    ,
    .audit_total (audit_total)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  int exp_q[$];
  bit mon_en = 1'b0;
  bit ack_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: turns DUT outputs into events and compares against the queue
  logic prev_ej = 1'b0, prev_f = 1'b0, ej;
  int   ev;
  always @(negedge clk) begin
    ej = bus.eject_q | bus.eject_d | bus.eject_n;
    if (reset || !mon_en) begin
      prev_ej = 1'b0;
      prev_f  = 1'b0;
    end else begin
      ev = 0;
      if (ej && $countones({bus.eject_q, bus.eject_d, bus.eject_n}) != 1)
        check("eject_onehot", $countones({bus.eject_q, bus.eject_d, bus.eject_n}), 1);
      if (ej && !prev_ej)           ev = bus.eject_q ? EV_Q : (bus.eject_d ? EV_D : EV_N);
      if (bus.done)                 ev = EV_DONE;
      if (bus.fault && !prev_f)     ev = 4 + int'(bus.err_code);
      if (ev != 0) begin
        if (exp_q.size() == 0) check("unexpected_event", ev, 0);
        else                   check("event", ev, exp_q.pop_front());
      end
      prev_ej = ej;
      prev_f  = bus.fault;
    end
  end

  // hopper model: acks one cycle after each eject becomes visible
  initial begin
    bus.coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || bus.coin_ack) bus.coin_ack = 1'b0;
      else if (ack_en && (bus.eject_q | bus.eject_d | bus.eject_n)) bus.coin_ack = 1'b1;
    end
  end

  task automatic pulse_start(input int amt);
    @(negedge clk);
    bus.change_amt = AMT_W'(amt);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); bus.clear_fault = 1'b1;
    @(negedge clk); bus.clear_fault = 1'b0;
  endtask

  task automatic pulse_refill();
    @(negedge clk); bus.refill = 1'b1;
    @(negedge clk); bus.refill = 1'b0;
  endtask

  task automatic settle(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check({name, "_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_inv(input string name, input int q, input int d, input int n);
    check({name, "_q"}, bus.q_cnt, q);
    check({name, "_d"}, bus.d_cnt, d);
    check({name, "_n"}, bus.n_cnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, hold;
    reset = 1'b1;
    bus.start = 1'b0; bus.change_amt = '0; bus.refill = 1'b0; bus.clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_eject", {bus.eject_q, bus.eject_d, bus.eject_n}, 0);
    check("rst_busy_done_fault", {bus.busy, bus.done, bus.fault}, 0);
    check("rst_err", bus.err_code, 0);
    check("rst_rem", bus.remaining, 0);
    check_inv("rst_inv", 8, 8, 8);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // 40c -> quarter, dime, nickel; eject two cycles after start
    ack_en = 1'b1;
    exp_q.push_back(EV_Q); exp_q.push_back(EV_D); exp_q.push_back(EV_N); exp_q.push_back(EV_DONE);
    pulse_start(40);
    check("lat_select_no_eject", bus.eject_q, 0);
    @(negedge clk);
    check("lat_eject_q", bus.eject_q, 1);
    settle("amt40");
    check_inv("amt40_inv", 7, 7, 7);
    check("amt40_rem", bus.remaining, 0);
`ifdef CHANGE_AUDIT_EN
    check("audit_40", audit_total, 40);
`endif

    // 0c -> straight to DONE, no eject
    exp_q.push_back(EV_DONE);
    pulse_start(0);
    check("amt0_busy", bus.busy, 1);
    check("amt0_done", bus.done, 1);
    settle("amt0");
    check("amt0_done_low", bus.done, 0);
    check_inv("amt0_inv", 7, 7, 7);

    // 7c -> not a multiple of 5
    exp_q.push_back(4 + 1);
    pulse_start(7);
    settle("amt7");
    check("amt7_fault", bus.fault, 1);
    check("amt7_err", bus.err_code, 1);
    check("amt7_busy", bus.busy, 0);
    pulse_clear();
    @(negedge clk);
    check("clr1_fault", bus.fault, 0);
    check("clr1_err", bus.err_code, 0);

    // drain the remaining 7 quarters
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(EV_Q); exp_q.push_back(EV_DONE);
      pulse_start(25);
      settle("drain_q");
    end
    check_inv("drained_inv", 0, 7, 7);

    // no quarters: 25c -> dime, dime, nickel
    exp_q.push_back(EV_D); exp_q.push_back(EV_D); exp_q.push_back(EV_N); exp_q.push_back(EV_DONE);
    pulse_start(25);
    settle("noq25");
    check("noq25_rem", bus.remaining, 0);
    check_inv("noq25_inv", 0, 5, 6);

    pulse_refill();
    @(negedge clk);
    check_inv("refill_inv", 8, 8, 8);

    // hopper never acks: quarter held TO cycles then fault 3, no deduction
    ack_en = 1'b0;
    exp_q.push_back(EV_Q); exp_q.push_back(4 + 3);
    pulse_start(25);
    k = 0;
    while (!bus.eject_q && k < 10) begin @(negedge clk); k++; end
    hold = 0;
    while (bus.eject_q && hold < 40) begin hold++; @(negedge clk); end
    check("timeout_hold", hold, TO);
    settle("timeout");
    check("timeout_fault", bus.fault, 1);
    check("timeout_err", bus.err_code, 3);
    check("timeout_rem", bus.remaining, 25);
    check_inv("timeout_inv", 8, 8, 8);
    pulse_clear();
    @(negedge clk);
    check("clr3_err", bus.err_code, 0);
    check("clr3_rem", bus.remaining, 0);

    // pay 15c so inventories differ from reset values
    ack_en = 1'b1;
    exp_q.push_back(EV_D); exp_q.push_back(EV_N); exp_q.push_back(EV_DONE);
    pulse_start(15);
    settle("amt15");
    check_inv("amt15_inv", 8, 7, 7);

    // reset while a dime is being ejected
    ack_en = 1'b0;
    exp_q.push_back(EV_D);
    pulse_start(10);
    k = 0;
    while (!bus.eject_d && k < 10) begin @(negedge clk); k++; end
    check("midrst_saw_eject", bus.eject_d, 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_eject_low", bus.eject_d, 0);
    check("midrst_busy", bus.busy, 0);
    check_inv("midrst_inv", 8, 8, 8);
`ifdef CHANGE_AUDIT_EN
    check("midrst_audit", audit_total, 0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
